// File: rtl/uart_rx_8n1_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encoding, default line
// parameters and the baud divider computation.
package uart_rx_8n1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } rx_state_t;

  localparam int unsigned CLK_FREQ_DEF   = 12000000;
  localparam int unsigned BAUD_DEF       = 9600;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Truncating divide: the receiver runs slightly fast rather than slow.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_8n1_baud_tick.sv
// Oversampling tick divider: one-cycle tick every DIV clocks, restartable by clr
// so the tick phase can be aligned to a detected start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == TC);

endmodule

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver with 16x oversampling, valid/ready holding register and
// framing/overrun error pulses.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | line idle, watching for a falling edge on rx_s
//   ST_START | waiting for start-bit mid-point to confirm (or reject glitch)
//   ST_DATA  | sampling 8 data bits at their mid-points, LSB first
//   ST_STOP  | sampling stop-bit mid-point; deliver byte or flag frame_err
//   ST_BRK   | stop bit was low; wait for line to return high
module uart_rx_8n1
  import uart_rx_8n1_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_TC = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_TC = TW'(OVERSAMPLE - 1);

  logic          rx_m, rx_s, rx_prev;
  rx_state_t     state_q, state_d;
  logic          tick, tick_clr;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          mid_half, mid_full;
  logic          shift_en, deliver_d, ferr_d, deliver_q;

  // Synchronizer resets high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign mid_half = tick && (tick_cnt == HALF_TC);
  assign mid_full = tick && (tick_cnt == FULL_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_clr  = 1'b0;
    shift_en  = 1'b0;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d  = ST_START;
          tick_clr = 1'b1;
        end
      end
      ST_START: begin
        if (mid_half) state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (mid_full) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid_full) begin
          if (rx_s) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BRK;
          end
        end
      end
      ST_BRK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick counter restarts at each sample point so every following sample
  // lands a whole bit later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      if (tick_clr || mid_full || (mid_half && state_q == ST_START)) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (tick_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
        shift_q <= {rx_s, shift_q[7:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deliver_q <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      deliver_q <= deliver_d;
      frame_err <= ferr_d;
      overrun   <= 1'b0;
      if (deliver_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: expected bytes go into a scoreboard queue,
// a negedge monitor pops them on each accepted transfer and tracks flag pulses.
module tb_uart_rx_8n1;

  // Faster line rate keeps the run short; DIV=10 exactly, 160 clk per bit.
  localparam int unsigned CLK_FREQ = 12000000;
  localparam int unsigned BAUD     = 75000;
  localparam int BIT      = 160;
  localparam int BIT_SLOW = 163;
  localparam int BIT_FAST = 157;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int fe_cnt = 0, ov_cnt = 0, vld_cyc = 0;
  int fe0, ov0, v0;
  logic prev_fe = 1'b0, prev_ov = 1'b0;

  always #5 clk = ~clk;

  uart_rx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_fe = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (rx_valid) vld_cyc++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=0x%0h required=none", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_data", int'(rx_data), int'(exp_b));
        end
      end
      if (frame_err) begin
        fe_cnt++;
        check("frame_err_width", int'(prev_fe), 0);
        check("flags_exclusive", int'(overrun), 0);
      end
      if (overrun) begin
        ov_cnt++;
        check("overrun_width", int'(prev_ov), 0);
      end
      prev_fe = frame_err;
      prev_ov = overrun;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(b[i], per);
    drive_bit(stop, per);
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0  = vld_cyc;
  endtask

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_flags", int'({frame_err, overrun}), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    drive_bit(1'b1, 50);

    // 1: single good frame
    snap();
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b1, BIT);
    drive_bit(1'b1, 20);
    check("t1_valid_cycles", vld_cyc - v0, 1);
    check("t1_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_queue", exp_q.size(), 0);

    // 2: short low pulse rejected as glitch
    snap();
    drive_bit(1'b0, 10);
    check("t2_busy_rise", int'(busy), 1);
    drive_bit(1'b0, 28);
    drive_bit(1'b1, 200);
    check("t2_busy_fall", int'(busy), 0);
    check("t2_no_output", (vld_cyc - v0) + (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // 3: framing error followed by held-low line
    snap();
    send_frame(8'h55, 1'b0, BIT);
    drive_bit(1'b0, 3 * BIT);
    check("t3_frame_err", fe_cnt - fe0, 1);
    check("t3_no_valid", vld_cyc - v0, 0);
    check("t3_busy_brk", int'(busy), 1);
    drive_bit(1'b1, 20);
    check("t3_busy_idle", int'(busy), 0);
    drive_bit(1'b1, 2 * BIT);

    // 4: back-to-back frames with consumer stalled
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT);
    send_frame(8'h3C, 1'b1, BIT);
    drive_bit(1'b1, 20);
    check("t4_overrun", ov_cnt - ov0, 1);
    check("t4_no_frame_err", fe_cnt - fe0, 0);
    check("t4_valid_held", int'(rx_valid), 1);
    check("t4_data_held", int'(rx_data), 8'hA5);
    rx_ready = 1'b1;
    drive_bit(1'b1, 3);
    check("t4_valid_clear", int'(rx_valid), 0);
    check("t4_queue", exp_q.size(), 0);

    // 5: reset in the middle of data bit 3 of 0x81
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT / 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_rst_data", int'(rx_data), 0);
    check("t5_rst_valid", int'(rx_valid), 0);
    check("t5_rst_flags", int'({frame_err, overrun}), 0);
    check("t5_rst_busy", int'(busy), 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 2 * BIT);
    snap();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, BIT);
    drive_bit(1'b1, 20);
    check("t5_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("t5_valid_cycles", vld_cyc - v0, 1);
    check("t5_queue", exp_q.size(), 0);

    // 6: baud mismatch, fast then slow transmitter
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, BIT_FAST);
    send_frame(8'hFF, 1'b1, BIT_SLOW);
    drive_bit(1'b1, 20);
    check("t6_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("t6_valid_cycles", vld_cyc - v0, 2);
    check("t6_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
